ttt_turn_sequencer: RTL and testbench

Top-level game controller for the tic-tac-toe board. It owns the 9-cell board register and alternates turns between the human input path and the CPU move engine. It drives the engine through a req/ack handshake and latches the difficulty for each game. After every move it checks for a win or draw and reports the result to the display logic.

---
 rtl/ttt_pkg.sv | 65 ++++++
 rtl/ttt_line_check.sv | 24 ++
 rtl/ttt_turn_sequencer.sv | 152 +++++++++++++++
 tb/tb_ttt_turn_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe encodings, controller state codes, win-line table and board helpers.
package ttt_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned CELL_W    = 2;
  localparam int unsigned BOARD_W   = NUM_CELLS * CELL_W;
  localparam int unsigned POS_W     = 4;
  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned STATE_W   = 3;

  localparam logic [CELL_W-1:0] CELL_X     = 2'd0;
  localparam logic [CELL_W-1:0] CELL_O     = 2'd1;
  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'd2;

  localparam logic [1:0] EASY   = 2'd0;
  localparam logic [1:0] MEDIUM = 2'd1;
  localparam logic [1:0] HARD   = 2'd2;

  localparam logic [STATE_W-1:0] S_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] S_HUMAN_WAIT = 3'd1;
  localparam logic [STATE_W-1:0] S_CPU_REQ    = 3'd2;
  localparam logic [STATE_W-1:0] S_CPU_WAIT   = 3'd3;
  localparam logic [STATE_W-1:0] S_CHECK      = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE       = 3'd5;

  localparam logic [BOARD_W-1:0] BOARD_EMPTY = 18'h2AAAA;

  typedef logic [POS_W-1:0] pos_t;
  typedef pos_t [2:0] line_t;

  // Rows, columns, then the two diagonals.
  localparam line_t [NUM_LINES-1:0] WIN_LINES = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [CELL_W-1:0] cell_at(input logic [BOARD_W-1:0] b, input pos_t pos);
    return b[CELL_W*int'(pos) +: CELL_W];
  endfunction

  // Only in-range empty cells accept a move.
  function automatic logic move_ok(input logic [BOARD_W-1:0] b, input pos_t pos);
    if (pos > pos_t'(NUM_CELLS - 1)) return 1'b0;
    return cell_at(b, pos) == CELL_EMPTY;
  endfunction

  function automatic logic [BOARD_W-1:0] with_cell(input logic [BOARD_W-1:0] b, input pos_t pos,
                                                   input logic [CELL_W-1:0] val);
    logic [BOARD_W-1:0] r;
    r = b;
    r[CELL_W*int'(pos) +: CELL_W] = val;
    return r;
  endfunction

  function automatic pos_t first_empty(input logic [BOARD_W-1:0] b);
    pos_t r;
    r = '0;
    for (int i = int'(NUM_CELLS) - 1; i >= 0; i--) begin
      if (b[CELL_W*i +: CELL_W] == CELL_EMPTY) r = pos_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win/full detector for one player on a packed 9-cell board.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [CELL_W-1:0]  player,
  output logic               win,
  output logic               full
);

  always_comb begin
    win  = 1'b0;
    full = 1'b1;
    for (int i = 0; i < int'(NUM_CELLS); i++) begin
      if (board[CELL_W*i +: CELL_W] == CELL_EMPTY) full = 1'b0;
    end
    for (int l = 0; l < int'(NUM_LINES); l++) begin
      if (cell_at(board, WIN_LINES[l][0]) == player &&
          cell_at(board, WIN_LINES[l][1]) == player &&
          cell_at(board, WIN_LINES[l][2]) == player) win = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_turn_sequencer.sv
// Game controller: owns the board, alternates human and CPU turns, handshakes with the
// move engine (with timeout fallback) and reports the winner.
module ttt_turn_sequencer
  import ttt_pkg::*;
#(
  parameter bit          HUMAN_FIRST = 1'b1,
  parameter int unsigned CPU_TIMEOUT = 1023,
  parameter int unsigned CNT_W       = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         difficulty,
  input  logic               human_valid,
  input  logic [POS_W-1:0]   human_pos,
  output logic               cpu_req,
  output logic [1:0]         cpu_mode,
  input  logic               cpu_ack,
  input  logic [POS_W-1:0]   cpu_pos,
  output logic [BOARD_W-1:0] board,
  output logic               human_turn,
  output logic               illegal_move,
  output logic               cpu_fallback,
  output logic               game_over,
  output logic [1:0]         winner
);

  logic [STATE_W-1:0] state, state_d;
  logic [BOARD_W-1:0] board_d;
  logic [1:0]         cpu_mode_d, winner_d;
  logic               cpu_req_d, human_turn_d, illegal_move_d, cpu_fallback_d, game_over_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               owner_o, owner_o_d;
  logic               line_win, board_full;

  // Judges the player who just moved, on the already-updated board.
  ttt_line_check u_line_check (
    .board  (board),
    .player (owner_o ? CELL_O : CELL_X),
    .win    (line_win),
    .full   (board_full)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      board        <= BOARD_EMPTY;
      cpu_mode     <= EASY;
      cpu_req      <= 1'b0;
      human_turn   <= 1'b0;
      illegal_move <= 1'b0;
      cpu_fallback <= 1'b0;
      game_over    <= 1'b0;
      winner       <= CELL_EMPTY;
      cnt          <= '0;
      owner_o      <= 1'b0;
    end else begin
      state        <= state_d;
      board        <= board_d;
      cpu_mode     <= cpu_mode_d;
      cpu_req      <= cpu_req_d;
      human_turn   <= human_turn_d;
      illegal_move <= illegal_move_d;
      cpu_fallback <= cpu_fallback_d;
      game_over    <= game_over_d;
      winner       <= winner_d;
      cnt          <= cnt_d;
      owner_o      <= owner_o_d;
    end
  end

  always_comb begin
    state_d        = state;
    board_d        = board;
    cpu_mode_d     = cpu_mode;
    cpu_req_d      = cpu_req;
    illegal_move_d = 1'b0;
    cpu_fallback_d = 1'b0;
    game_over_d    = game_over;
    winner_d       = winner;
    cnt_d          = cnt;
    owner_o_d      = owner_o;

    if (start) begin
      state_d     = HUMAN_FIRST ? S_HUMAN_WAIT : S_CPU_REQ;
      board_d     = BOARD_EMPTY;
      cpu_mode_d  = (difficulty == 2'd3) ? HARD : difficulty;
      cpu_req_d   = 1'b0;
      game_over_d = 1'b0;
      winner_d    = CELL_EMPTY;
      cnt_d       = '0;
    end else begin
      case (state)
        S_HUMAN_WAIT: begin
          if (human_valid) begin
            if (move_ok(board, human_pos)) begin
              board_d   = with_cell(board, human_pos, CELL_X);
              owner_o_d = 1'b0;
              state_d   = S_CHECK;
            end else begin
              illegal_move_d = 1'b1;
            end
          end
        end
        S_CPU_REQ: begin
          cpu_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_CPU_WAIT;
        end
        S_CPU_WAIT: begin
          cnt_d = cnt + CNT_W'(1);
          // A same-cycle ack takes priority over the timeout.
          if (cpu_ack) begin
            if (move_ok(board, cpu_pos)) begin
              board_d   = with_cell(board, cpu_pos, CELL_O);
              owner_o_d = 1'b1;
              cpu_req_d = 1'b0;
              state_d   = S_CHECK;
            end else begin
              illegal_move_d = 1'b1;
              state_d        = S_CPU_REQ;
            end
          end else if (cnt == CNT_W'(CPU_TIMEOUT - 1)) begin
            board_d        = with_cell(board, first_empty(board), CELL_O);
            owner_o_d      = 1'b1;
            cpu_fallback_d = 1'b1;
            cpu_req_d      = 1'b0;
            state_d        = S_CHECK;
          end
        end
        S_CHECK: begin
          if (line_win) begin
            winner_d    = owner_o ? CELL_O : CELL_X;
            game_over_d = 1'b1;
            state_d     = S_DONE;
          end else if (board_full) begin
            winner_d    = CELL_EMPTY;
            game_over_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = owner_o ? S_HUMAN_WAIT : S_CPU_REQ;
          end
        end
        default: begin
        end
      endcase
    end

    human_turn_d = (state_d == S_HUMAN_WAIT);
  end

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Self-checking bench: directed scenarios plus random games against a cell-array game model.
module tb_ttt_turn_sequencer;

  localparam int TIMEOUT = 1023;

  logic        clock;
  logic        reset_n, start, human_valid, cpu_ack;
  logic [1:0]  difficulty;
  logic [3:0]  human_pos, cpu_pos;
  logic        cpu_req, human_turn, illegal_move, cpu_fallback, game_over;
  logic [1:0]  cpu_mode, winner;
  logic [17:0] board;

  int checks = 0;
  int failures = 0;
  int mb[9];
  bit over;
  int exp_mode;

  ttt_turn_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .difficulty   (difficulty),
    .human_valid  (human_valid),
    .human_pos    (human_pos),
    .cpu_req      (cpu_req),
    .cpu_mode     (cpu_mode),
    .cpu_ack      (cpu_ack),
    .cpu_pos      (cpu_pos),
    .board        (board),
    .human_turn   (human_turn),
    .illegal_move (illegal_move),
    .cpu_fallback (cpu_fallback),
    .game_over    (game_over),
    .winner       (winner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [17:0] exp_board();
    logic [17:0] b;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(mb[i]);
    return b;
  endfunction

  function automatic bit won(int p);
    for (int r = 0; r < 3; r++)
      if (mb[3*r] == p && mb[3*r+1] == p && mb[3*r+2] == p) return 1;
    for (int c = 0; c < 3; c++)
      if (mb[c] == p && mb[c+3] == p && mb[c+6] == p) return 1;
    if (mb[0] == p && mb[4] == p && mb[8] == p) return 1;
    if (mb[2] == p && mb[4] == p && mb[6] == p) return 1;
    return 0;
  endfunction

  function automatic bit full();
    foreach (mb[i]) if (mb[i] == 2) return 0;
    return 1;
  endfunction

  function automatic int lowest_empty();
    foreach (mb[i]) if (mb[i] == 2) return i;
    return 0;
  endfunction

  function automatic int random_empty();
    int k = 0;
    int cand[$];
    foreach (mb[i]) if (mb[i] == 2) cand.push_back(i);
    if (cand.size() == 0) return 0;
    k = $urandom_range(0, cand.size() - 1);
    return cand[k];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic new_game(int d);
    start = 1'b1;
    difficulty = 2'(d);
    step();
    start = 1'b0;
    foreach (mb[i]) mb[i] = 2;
    over = 0;
    exp_mode = (d == 3) ? 2 : d;
    chk("start_board", board, exp_board());
    chk("start_human_turn", human_turn, 1);
    chk("start_cpu_req", cpu_req, 0);
    chk("start_game_over", game_over, 0);
    chk("start_cpu_mode", cpu_mode, exp_mode);
  endtask

  // The CHECK cycle after a move by owner (0 = X, 1 = O).
  task automatic settle(int owner);
    step();
    if (won(owner)) begin
      over = 1;
      chk("win_game_over", game_over, 1);
      chk("win_winner", winner, owner);
      chk("win_human_turn", human_turn, 0);
    end else if (full()) begin
      over = 1;
      chk("draw_game_over", game_over, 1);
      chk("draw_winner", winner, 2);
    end else begin
      chk("next_game_over", game_over, 0);
      chk("next_human_turn", human_turn, owner);
      chk("next_cpu_req", cpu_req, 0);
    end
  endtask

  task automatic human(int pos, output bit ok);
    human_pos = 4'(pos);
    human_valid = 1'b1;
    step();
    human_valid = 1'b0;
    if (over) begin
      ok = 1;
      chk("done_board", board, exp_board());
      chk("done_illegal", illegal_move, 0);
      chk("done_game_over", game_over, 1);
      return;
    end
    ok = (pos <= 8) ? (mb[pos] == 2) : 0;
    if (!ok) begin
      chk("h_illegal", illegal_move, 1);
      chk("h_illegal_turn", human_turn, 1);
      chk("h_illegal_board", board, exp_board());
    end else begin
      mb[pos] = 0;
      chk("h_board", board, exp_board());
      chk("h_no_illegal", illegal_move, 0);
      chk("h_turn_drop", human_turn, 0);
      settle(0);
    end
  endtask

  task automatic cpu(int delay, int pos, output bit ok);
    step();
    chk("c_req_rise", cpu_req, 1);
    chk("c_mode", cpu_mode, exp_mode);
    chk("c_human_turn", human_turn, 0);
    repeat (delay) begin
      step();
      chk("c_req_hold", cpu_req, 1);
    end
    cpu_pos = 4'(pos);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    ok = (pos <= 8) ? (mb[pos] == 2) : 0;
    if (ok) begin
      mb[pos] = 1;
      chk("c_board", board, exp_board());
      chk("c_req_drop", cpu_req, 0);
      chk("c_no_illegal", illegal_move, 0);
      chk("c_no_fallback", cpu_fallback, 0);
      settle(1);
    end else begin
      chk("c_illegal", illegal_move, 1);
      chk("c_req_kept", cpu_req, 1);
      chk("c_illegal_board", board, exp_board());
    end
  endtask

  task automatic cpu_timeout(bit ack_last, int pos);
    int n = 0;
    step();
    chk("t_req_rise", cpu_req, 1);
    if (ack_last) begin
      repeat (TIMEOUT - 1) begin
        step();
        if (cpu_fallback !== 1'b0 || cpu_req !== 1'b1) n++;
      end
      chk("t_early_fallback", n, 0);
      cpu_pos = 4'(pos);
      cpu_ack = 1'b1;
      step();
      cpu_ack = 1'b0;
      mb[pos] = 1;
      chk("t_ack_wins_board", board, exp_board());
      chk("t_ack_wins_no_fb", cpu_fallback, 0);
      chk("t_ack_wins_req", cpu_req, 0);
      settle(1);
    end else begin
      while (cpu_fallback !== 1'b1 && n < TIMEOUT + 80) begin
        step();
        n++;
      end
      chk("t_timeout_cycles", n, TIMEOUT);
      mb[lowest_empty()] = 1;
      chk("t_fallback_board", board, exp_board());
      chk("t_fallback_req", cpu_req, 0);
      settle(1);
      chk("t_fallback_pulse", cpu_fallback, 0);
    end
  endtask

  task automatic random_game();
    bit ok;
    int pos;
    int tries;
    new_game($urandom_range(0, 3));
    while (!over) begin
      tries = 0;
      ok = 0;
      while (!ok) begin
        pos = (tries > 3 || $urandom_range(0, 3) != 0) ? random_empty() : int'($urandom_range(0, 15));
        human(pos, ok);
        tries++;
      end
      if (!over) begin
        tries = 0;
        ok = 0;
        while (!ok) begin
          pos = (tries > 3 || $urandom_range(0, 3) != 0) ? random_empty() : int'($urandom_range(0, 15));
          cpu($urandom_range(0, 4), pos, ok);
          tries++;
        end
      end
    end
  endtask

  initial begin
    bit ok;
    reset_n = 1'b0;
    start = 1'b0;
    difficulty = 2'd0;
    human_valid = 1'b0;
    human_pos = 4'd0;
    cpu_ack = 1'b0;
    cpu_pos = 4'd0;
    foreach (mb[i]) mb[i] = 2;
    over = 0;
    exp_mode = 0;
    #12;
    chk("rst_board", board, 18'h2AAAA);
    chk("rst_cpu_req", cpu_req, 0);
    chk("rst_human_turn", human_turn, 0);
    chk("rst_winner", winner, 2);
    chk("rst_cpu_mode", cpu_mode, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_illegal", illegal_move, 0);
    chk("rst_fallback", cpu_fallback, 0);
    reset_n = 1'b1;
    step();

    // IDLE ignores moves.
    human_pos = 4'd4;
    human_valid = 1'b1;
    step();
    human_valid = 1'b0;
    chk("idle_board", board, 18'h2AAAA);
    chk("idle_human_turn", human_turn, 0);

    // Basic exchange, illegal moves, timeout fallback, ack on the timeout cycle.
    new_game(1);
    human(4, ok);
    cpu(2, 0, ok);
    human(4, ok);
    human(9, ok);
    human(8, ok);
    cpu_timeout(1'b0, 0);
    human(3, ok);
    cpu_timeout(1'b1, 6);

    // X wins on the top row; DONE ignores later moves.
    new_game(3);
    human(0, ok);
    cpu(0, 3, ok);
    human(1, ok);
    cpu(1, 4, ok);
    human(2, ok);
    human(5, ok);

    // Full-board draw; a late engine ack is ignored.
    new_game(0);
    human(0, ok);
    cpu(0, 1, ok);
    human(2, ok);
    cpu(1, 4, ok);
    human(3, ok);
    cpu(0, 5, ok);
    human(7, ok);
    cpu(2, 6, ok);
    human(8, ok);
    cpu_pos = 4'd5;
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    chk("done_ack_board", board, exp_board());
    chk("done_ack_winner", winner, 2);
    chk("done_ack_over", game_over, 1);

    // Start mid-CPU_WAIT beats a same-cycle ack.
    new_game(2);
    human(0, ok);
    step();
    chk("mid_req_up", cpu_req, 1);
    step();
    start = 1'b1;
    difficulty = 2'd1;
    cpu_pos = 4'd5;
    cpu_ack = 1'b1;
    step();
    start = 1'b0;
    cpu_ack = 1'b0;
    foreach (mb[i]) mb[i] = 2;
    over = 0;
    exp_mode = 1;
    chk("mid_start_board", board, 18'h2AAAA);
    chk("mid_start_req", cpu_req, 0);
    chk("mid_start_turn", human_turn, 1);
    chk("mid_start_mode", cpu_mode, 1);

    repeat (6) random_game();

    // Asynchronous reset during the handshake.
    new_game(2);
    human(4, ok);
    step();
    chk("rst_mid_req_up", cpu_req, 1);
    reset_n = 1'b0;
    #2;
    chk("rst_mid_req", cpu_req, 0);
    chk("rst_mid_board", board, 18'h2AAAA);
    chk("rst_mid_mode", cpu_mode, 0);
    chk("rst_mid_turn", human_turn, 0);
    chk("rst_mid_winner", winner, 2);
    reset_n = 1'b1;
    step();
    cpu_pos = 4'd2;
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    chk("idle_ack_board", board, 18'h2AAAA);
    chk("idle_ack_req", cpu_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
